shift_ctrl: RTL and testbench

SHIFT_CTRL -- requirements
Module: shift_ctrl

---
 rtl/shift_ctrl_if.sv | 27 ++
 rtl/shift_ctrl.sv | 113 +++++++++++
 tb/tb_shift_ctrl.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/shift_ctrl_if.sv
// Handshake bundle between a requester/datapath and the shift controller.
// The master side issues requests and reports the datapath MSB; the slave side is the controller.
interface shift_ctrl_if #(
  parameter int CNT_W = 5
);
  logic             start;
  logic [CNT_W-1:0] amount;
  logic             mode;
  logic             msb;
  logic             ack;
  logic             load;
  logic             shift_en;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] shift_count;
  logic             zero_flag;

  modport master (
    output start, amount, mode, msb, ack,
    input  load, shift_en, busy, done, shift_count, zero_flag
  );

  modport slave (
    input  start, amount, mode, msb, ack,
    output load, shift_en, busy, done, shift_count, zero_flag
  );
endinterface

// File: rtl/shift_ctrl.sv
// Sequencer for an external shift-register datapath: parallel load, then a fixed
// number of shifts or a normalize run that stops at the first MSB=1, then a held result.
module shift_ctrl #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic        clk,
  input  logic        rst,
  shift_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);

  state_t           state_r;
  state_t           state_nxt_s;
  logic [CNT_W-1:0] amt_r;
  logic [CNT_W-1:0] cnt_r;
  logic             mode_r;
  logic             zero_r;
  logic             shift_s;

  // Shift strobe must react in the same cycle the datapath MSB becomes 1.
  assign shift_s = (state_r == SHIFT) && (cnt_r < amt_r) && !(mode_r && bus.msb);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode; start is only honoured in IDLE, ack only in DONE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          state_nxt_s = LOAD;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      LOAD: begin
        state_nxt_s = SHIFT;
      end
      SHIFT: begin
        if (shift_s) begin
          state_nxt_s = SHIFT;
        end else begin
          state_nxt_s = DONE;
        end
      end
      DONE: begin
        if (bus.ack) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = DONE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Operation context: latched request, shift counter and normalize result flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      amt_r  <= {CNT_W{1'b0}};
      mode_r <= 1'b0;
      cnt_r  <= {CNT_W{1'b0}};
      zero_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.start) begin
            amt_r  <= (bus.amount > WIDTH_C) ? WIDTH_C : bus.amount;
            mode_r <= bus.mode;
            cnt_r  <= {CNT_W{1'b0}};
            zero_r <= 1'b0;
          end
        end
        SHIFT: begin
          if (shift_s) begin
            cnt_r <= cnt_r + CNT_W'(1);
          end else if (mode_r && !bus.msb) begin
            zero_r <= 1'b1;
          end
        end
        default: begin
          cnt_r <= cnt_r;
        end
      endcase
    end
  end

  assign bus.load        = (state_r == LOAD);
  assign bus.shift_en    = shift_s;
  assign bus.busy        = (state_r != IDLE);
  assign bus.done        = (state_r == DONE);
  assign bus.shift_count = cnt_r;
  assign bus.zero_flag   = zero_r;

endmodule

// File: tb/tb_shift_ctrl.sv
// Randomized bench for shift_ctrl: drives a behavioural shift register datapath and
// compares timing, counts and flags against a request-level reference model.
module tb_shift_ctrl;
  localparam int WIDTH = 16;
  localparam int CNT_W = 5;

  logic clk = 1'b0;
  logic rst;
  logic [WIDTH-1:0] dp;
  logic [WIDTH-1:0] load_val;
  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  shift_ctrl_if #(.CNT_W(CNT_W)) bus ();

  shift_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Datapath being controlled.
  always @(posedge clk) begin
    if (bus.load) dp <= load_val;
    else if (bus.shift_en) dp <= dp << 1;
  end
  assign bus.msb = dp[WIDTH-1];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return {26'd0, bus.load, bus.shift_en, bus.busy, bus.done, bus.zero_flag, |bus.shift_count};
  endfunction

  task automatic run_op(input int amount_in, input bit mode_in, input logic [WIDTH-1:0] val,
                        input bit noisy);
    int amt, n;
    int load_cnt = 0, load_first = 0, sh_cnt = 0, sh_first = 0, sh_last = 0;
    int done_first = 0, overlap = 0, busy_bad = 0;
    logic [WIDTH-1:0] v;
    bit exp_zf;
    amt = (amount_in > WIDTH) ? WIDTH : amount_in;
    v = val;
    n = 0;
    if (!mode_in) n = amt;
    else while (n < amt && !v[WIDTH-1]) begin v = v << 1; n++; end
    v = val << n;
    exp_zf = mode_in && !v[WIDTH-1];

    @(negedge clk);
    load_val   = val;
    bus.start  = 1'b1;
    bus.amount = CNT_W'(amount_in);
    bus.mode   = mode_in;
    bus.ack    = 1'b0;
    @(posedge clk);
    for (int k = 1; k <= 40 && done_first == 0; k++) begin
      @(negedge clk);
      if (bus.load) begin load_cnt++; if (load_first == 0) load_first = k; end
      if (bus.shift_en) begin sh_cnt++; if (sh_first == 0) sh_first = k; sh_last = k; end
      if (bus.load && bus.shift_en) overlap++;
      if (bus.done) done_first = k;
      else if (bus.busy !== 1'b1) busy_bad++;
      if (noisy && done_first == 0) begin
        bus.start  = 1'b1;
        bus.amount = CNT_W'($urandom_range(0, 31));
        bus.mode   = 1'($urandom_range(0, 1));
        bus.ack    = (k <= 2);
      end else begin
        bus.start = 1'b0;
        bus.ack   = 1'b0;
      end
    end
    check("done_latency", done_first, n + 3);
    check("load_pulses", load_cnt, 1);
    check("load_cycle", load_first, 1);
    check("shift_pulses", sh_cnt, n);
    check("shift_first", sh_first, (n > 0) ? 2 : 0);
    check("shift_last", sh_last, (n > 0) ? n + 1 : 0);
    check("load_shift_overlap", overlap, 0);
    check("busy_while_active", busy_bad, 0);
    for (int h = 0; h < 2; h++) begin
      @(negedge clk);
      check("done_held", bus.done, 1);
      check("shift_count", bus.shift_count, n);
      check("zero_flag", bus.zero_flag, exp_zf);
      check("no_strobe_in_done", {bus.load, bus.shift_en}, 0);
      check("datapath", dp, v);
    end
    bus.start = 1'b1;
    bus.ack   = 1'b1;
    @(negedge clk);
    check("ack_to_idle_busy", bus.busy, 0);
    check("ack_to_idle_done", bus.done, 0);
    bus.start = 1'b0;
    bus.ack   = 1'b0;
    @(negedge clk);
    check("start_with_ack_ignored", {bus.busy, bus.load}, 0);
    check("count_kept_in_idle", bus.shift_count, n);
  endtask

  task automatic reset_midop();
    int seen = 0;
    @(negedge clk);
    load_val   = 16'h0001;
    bus.start  = 1'b1;
    bus.amount = CNT_W'(16);
    bus.mode   = 1'b0;
    @(posedge clk);
    for (int k = 0; k < 20 && seen < 2; k++) begin
      @(negedge clk);
      if (bus.shift_en) seen++;
      bus.amount = CNT_W'(3);
    end
    check("two_shifts_before_rst", seen, 2);
    #2 rst = 1'b1;
    #1 check("outs_at_rst", all_outs(), 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("outs_during_rst", all_outs(), 0);
    end
    rst = 1'b0;
    bus.start = 1'b0;
    @(negedge clk);
    check("outs_after_rst", all_outs(), 0);
  endtask

  initial begin
    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.amount = '0;
    bus.mode   = 1'b0;
    bus.ack    = 1'b0;
    load_val   = '0;
    #1 check("reset_outputs", all_outs(), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("idle_after_reset", all_outs(), 0);

    run_op(3, 1'b0, 16'hA5A5, 1'b0);
    run_op(0, 1'b0, 16'h1234, 1'b0);
    run_op(20, 1'b0, 16'h0001, 1'b0);
    run_op(16, 1'b1, 16'h0100, 1'b0);
    run_op(16, 1'b1, 16'h0000, 1'b0);
    run_op(16, 1'b1, 16'h8000, 1'b0);
    run_op(4, 1'b1, 16'h0001, 1'b1);
    reset_midop();
    run_op(5, 1'b0, 16'h00F0, 1'b0);
    for (int i = 0; i < 25; i++) begin
      logic [WIDTH-1:0] r;
      r = WIDTH'($urandom);
      r = r >> $urandom_range(0, 16);
      run_op($urandom_range(0, 31), 1'($urandom_range(0, 1)), r, 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
